nfc_command_dispatcher: RTL and testbench
=========================================

Name: nfc_command_dispatcher

Overview:
- Shares the single atomic-command-generator (ACG) port between NumOfCommands command-sequencer modules (reset, set-feature, read-ID, page program, and others).
- Latches the sequencer that decodes the incoming command, owns the ACG bus until that sequencer reports its last step, then releases it.
- Provides host command ready, completion pulse, conflict detect, unknown-opcode detect and a watchdog.
- Sits between the host command interface and the ACG.

Parameters:
NumberOfWays, 4, number of NAND ways (width of target-way and ready/busy vectors)
NumOfCommands, 4, number of attached command sequencers (N)
TimeoutWidth, 20, watchdog counter width; timeout at 2^TimeoutWidth-1 busy cycles

Ports:
iSystemClock  in  1  system clock
iReset  in  1  synchronous active-high reset
iCMDValid  in  1  host command valid, broadcast to all sequencers
oCMDReady  out  1  dispatcher accepting a new command
iSeqStart  in  N  per-sequencer oStart (opcode/target decode & valid)
iSeqLastStep  in  N  per-sequencer oLastStep
iSeqACG_Command  in  8N  per-sequencer flattened; slot k = [8k+7:8k]
iSeqACG_CommandOption  in  3N  flattened
iSeqACG_TargetWay  in  NumberOfWays*N  flattened
iSeqACG_NumOfData  in  16N  flattened
iSeqACG_CASelect  in  N  per-sequencer
iSeqACG_CAData  in  40N  flattened
iSeqACG_WriteData  in  16N  flattened
iSeqACG_WriteLast  in  N  per-sequencer
iSeqACG_WriteValid  in  N  per-sequencer
oSeqACG_LastStep  out  8N  ACG last-step, gated per sequencer
oSeqACG_WriteReady  out  N  ACG write-ready, gated per sequencer
oACG_Command  out  8  muxed to ACG
oACG_CommandOption  out  3  muxed
oACG_TargetWay  out  NumberOfWays  muxed
oACG_NumOfData  out  16  muxed
oACG_CASelect  out  1  muxed
oACG_CAData  out  40  muxed
oACG_WriteData  out  16  muxed
oACG_WriteLast  out  1  muxed
oACG_WriteValid  out  1  muxed
iACG_LastStep  in  8  from ACG
iACG_WriteReady  in  1  from ACG
oGrant  out  N  one-hot owner, 0 when idle
oLastStep  out  1  one-cycle completion pulse
oConflict  out  1  one-cycle pulse: more than one iSeqStart bit at grant
oUnknownCmd  out  1  one-cycle pulse: iCMDValid in IDLE with iSeqStart==0
oTimeout  out  1  sticky watchdog flag

Behaviour:
- Reset (synchronous, iReset high at posedge):
  - state IDLE, rGrant=0, counter=0.
  - oCMDReady=1; oLastStep, oConflict, oUnknownCmd and oTimeout all 0.
  - Reset mid-operation drops ownership immediately; the next cycle shows idle bus values.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - oCMDReady=1.
  - If any iSeqStart bit is set: rGrant takes the lowest-index set bit on the clock edge; go to BUSY; counter cleared; oTimeout cleared.
  - oConflict=1 for one cycle (registered) if popcount(iSeqStart)>1.
  - If iCMDValid=1 and iSeqStart=0: oUnknownCmd=1 for one cycle; stay in IDLE.
- BUSY:
  - oCMDReady=0.
  - Counter increments each cycle and saturates at all-ones; on reaching all-ones, oTimeout=1, held until the next grant or reset. State is unchanged.
  - On iSeqLastStep[owner]=1: oLastStep pulses 1 the next cycle; go to RELEASE.
  - iSeqLastStep on non-owner slots and iSeqStart are ignored.
- RELEASE: one cycle, oCMDReady=0, rGrant=0; then IDLE. This guarantees the owner has returned to its ready state before a new grant.
- ACG mux (combinational from rGrant):
  - When rGrant is non-zero, every oACG_* output equals the owner's slot.
  - When rGrant=0, outputs take idle values: Command=0, CommandOption=0, TargetWay=0, NumOfData=0, CASelect=1, CAData=0, WriteData=0, WriteLast=0, WriteValid=0.
- Return gating:
  - oSeqACG_LastStep slot k = iACG_LastStep when rGrant[k], else 0.
  - oSeqACG_WriteReady[k] = iACG_WriteReady & rGrant[k].
- Latency:
  - Grant is visible the cycle after iSeqStart, which matches the first registered ACG command from the sequencer.
  - From owner LastStep to oCMDReady=1 is 2 cycles.
- Simultaneous LastStep from owner and iSeqStart in the same cycle: the start is not granted, and oUnknownCmd is not raised (state is not IDLE).

Test Plan:
- Reset, then iSeqStart=4'b0010 for one cycle -> next cycle oGrant=0010, oCMDReady=0, oACG_CAData=slot1 value (e.g. 40'hef_00_00_00_00).
- Owner slot1 asserts iSeqLastStep[1] -> oLastStep=1 next cycle; oGrant=0 in RELEASE; oCMDReady=1 two cycles after LastStep; idle bus CASelect=1, Command=0.
- iSeqStart=4'b0110 -> oGrant=0010, oConflict one-cycle pulse; iACG_WriteReady=1 appears only on oSeqACG_WriteReady[1].
- iCMDValid=1 with iSeqStart=0 in IDLE -> oUnknownCmd one-cycle pulse, oGrant stays 0; in BUSY the same stimulus -> no pulse.
- TimeoutWidth=4: grant with no LastStep -> oTimeout=1 at busy cycle 15 and stays set; the next grant clears it.
- iReset asserted while BUSY -> next cycle oGrant=0, oCMDReady=1, all oACG_* at idle values.

Source files
------------

// File: rtl/nfc_command_dispatcher.sv
// nfc_command_dispatcher
//
// Shares the single atomic-command-generator (ACG) port between NumOfCommands
// command sequencers. The sequencer whose iSeqStart is set while idle (lowest
// index wins) is latched as owner. It keeps the ACG bus until it reports its
// last step. A one-cycle release state follows, then the dispatcher is ready
// for the next command.
//
// Ports:
//   iSystemClock, iReset     clock, synchronous active-high reset
//   iCMDValid / oCMDReady    host command handshake (valid is broadcast)
//   iSeqStart, iSeqLastStep  per-sequencer start / last-step strobes
//   iSeqACG_*                per-sequencer flattened ACG requests (slot k)
//   oSeqACG_*                ACG returns, gated to the owner slot only
//   oACG_*, iACG_*           the shared ACG port
//   oGrant                   one-hot owner, zero when no owner
//   oLastStep                one-cycle completion pulse
//   oConflict                one-cycle pulse: several starts at grant time
//   oUnknownCmd              one-cycle pulse: valid command nobody decoded
//   oTimeout                 sticky watchdog flag, cleared by the next grant
module nfc_command_dispatcher #(
  parameter int unsigned NumberOfWays  = 4,
  parameter int unsigned NumOfCommands = 4,
  parameter int unsigned TimeoutWidth  = 20
) (
  input  logic                                  iSystemClock,
  input  logic                                  iReset,
  input  logic                                  iCMDValid,
  output logic                                  oCMDReady,
  input  logic [NumOfCommands-1:0]              iSeqStart,
  input  logic [NumOfCommands-1:0]              iSeqLastStep,
  input  logic [8*NumOfCommands-1:0]            iSeqACG_Command,
  input  logic [3*NumOfCommands-1:0]            iSeqACG_CommandOption,
  input  logic [NumberOfWays*NumOfCommands-1:0] iSeqACG_TargetWay,
  input  logic [16*NumOfCommands-1:0]           iSeqACG_NumOfData,
  input  logic [NumOfCommands-1:0]              iSeqACG_CASelect,
  input  logic [40*NumOfCommands-1:0]           iSeqACG_CAData,
  input  logic [16*NumOfCommands-1:0]           iSeqACG_WriteData,
  input  logic [NumOfCommands-1:0]              iSeqACG_WriteLast,
  input  logic [NumOfCommands-1:0]              iSeqACG_WriteValid,
  output logic [8*NumOfCommands-1:0]            oSeqACG_LastStep,
  output logic [NumOfCommands-1:0]              oSeqACG_WriteReady,
  output logic [7:0]                            oACG_Command,
  output logic [2:0]                            oACG_CommandOption,
  output logic [NumberOfWays-1:0]               oACG_TargetWay,
  output logic [15:0]                           oACG_NumOfData,
  output logic                                  oACG_CASelect,
  output logic [39:0]                           oACG_CAData,
  output logic [15:0]                           oACG_WriteData,
  output logic                                  oACG_WriteLast,
  output logic                                  oACG_WriteValid,
  input  logic [7:0]                            iACG_LastStep,
  input  logic                                  iACG_WriteReady,
  output logic [NumOfCommands-1:0]              oGrant,
  output logic                                  oLastStep,
  output logic                                  oConflict,
  output logic                                  oUnknownCmd,
  output logic                                  oTimeout
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusy    = 2'd1,
    StRelease = 2'd2
  } state_e;

  localparam logic [TimeoutWidth-1:0] CounterMax = '1;

  state_e                    rState, wNextState;
  logic [NumOfCommands-1:0]  rGrant, wNextGrant;
  logic [TimeoutWidth-1:0]   rCounter, wNextCounter;
  logic                      rLastStep, wNextLastStep;
  logic                      rConflict, wNextConflict;
  logic                      rUnknownCmd, wNextUnknownCmd;
  logic                      rTimeout, wNextTimeout;

  logic [NumOfCommands-1:0]  wLowestStart;
  logic                      wMultiStart;
  logic                      wOwnerLastStep;

  // x & -x isolates the lowest set bit; x & (x-1) is non-zero for two or more bits.
  assign wLowestStart   = iSeqStart & (~iSeqStart + NumOfCommands'(1));
  assign wMultiStart    = |(iSeqStart & (iSeqStart - NumOfCommands'(1)));
  assign wOwnerLastStep = |(iSeqLastStep & rGrant);

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      rState      <= StIdle;
      rGrant      <= '0;
      rCounter    <= '0;
      rLastStep   <= 1'b0;
      rConflict   <= 1'b0;
      rUnknownCmd <= 1'b0;
      rTimeout    <= 1'b0;
    end else begin
      rState      <= wNextState;
      rGrant      <= wNextGrant;
      rCounter    <= wNextCounter;
      rLastStep   <= wNextLastStep;
      rConflict   <= wNextConflict;
      rUnknownCmd <= wNextUnknownCmd;
      rTimeout    <= wNextTimeout;
    end
  end

  always_comb begin
    wNextState      = rState;
    wNextGrant      = rGrant;
    wNextCounter    = rCounter;
    wNextLastStep   = 1'b0;
    wNextConflict   = 1'b0;
    wNextUnknownCmd = 1'b0;
    wNextTimeout    = rTimeout;
    unique case (rState)
      StIdle: begin
        if (|iSeqStart) begin
          wNextState    = StBusy;
          wNextGrant    = wLowestStart;
          wNextCounter  = '0;
          wNextTimeout  = 1'b0;
          wNextConflict = wMultiStart;
        end else if (iCMDValid) begin
          wNextUnknownCmd = 1'b1;
        end
      end
      StBusy: begin
        // Saturating watchdog; the flag rises on the edge the counter hits all-ones.
        if (rCounter != CounterMax) begin
          wNextCounter = rCounter + TimeoutWidth'(1);
        end
        if (wNextCounter == CounterMax) begin
          wNextTimeout = 1'b1;
        end
        if (wOwnerLastStep) begin
          wNextState    = StRelease;
          wNextGrant    = '0;
          wNextLastStep = 1'b1;
        end
      end
      StRelease: begin
        // Gives the finished sequencer a cycle to return to ready before any new grant.
        wNextState = StIdle;
        wNextGrant = '0;
      end
      default: begin
        wNextState = StIdle;
        wNextGrant = '0;
      end
    endcase
  end

  assign oCMDReady   = (rState == StIdle);
  assign oGrant      = rGrant;
  assign oLastStep   = rLastStep;
  assign oConflict   = rConflict;
  assign oUnknownCmd = rUnknownCmd;
  assign oTimeout    = rTimeout;

  // ACG request mux; rGrant is one-hot or zero, so at most one slot matches.
  always_comb begin
    oACG_Command       = '0;
    oACG_CommandOption = '0;
    oACG_TargetWay     = '0;
    oACG_NumOfData     = '0;
    oACG_CASelect      = 1'b1;
    oACG_CAData        = '0;
    oACG_WriteData     = '0;
    oACG_WriteLast     = 1'b0;
    oACG_WriteValid    = 1'b0;
    for (int k = 0; k < NumOfCommands; k++) begin
      if (rGrant[k]) begin
        oACG_Command       = iSeqACG_Command[8*k +: 8];
        oACG_CommandOption = iSeqACG_CommandOption[3*k +: 3];
        oACG_TargetWay     = iSeqACG_TargetWay[NumberOfWays*k +: NumberOfWays];
        oACG_NumOfData     = iSeqACG_NumOfData[16*k +: 16];
        oACG_CASelect      = iSeqACG_CASelect[k];
        oACG_CAData        = iSeqACG_CAData[40*k +: 40];
        oACG_WriteData     = iSeqACG_WriteData[16*k +: 16];
        oACG_WriteLast     = iSeqACG_WriteLast[k];
        oACG_WriteValid    = iSeqACG_WriteValid[k];
      end
    end
  end

  // ACG returns reach only the owner.
  always_comb begin
    oSeqACG_LastStep = '0;
    for (int k = 0; k < NumOfCommands; k++) begin
      if (rGrant[k]) begin
        oSeqACG_LastStep[8*k +: 8] = iACG_LastStep;
      end
    end
  end

  assign oSeqACG_WriteReady = rGrant & {NumOfCommands{iACG_WriteReady}};

endmodule

// File: tb/tb_nfc_command_dispatcher.sv
module tb_nfc_command_dispatcher;

  localparam int unsigned Ways = 4;
  localparam int unsigned Cmds = 4;
  localparam int unsigned TW   = 4;

  logic              iSystemClock;
  logic              iReset;
  logic              iCMDValid;
  logic              oCMDReady;
  logic [Cmds-1:0]   iSeqStart;
  logic [Cmds-1:0]   iSeqLastStep;
  logic [8*Cmds-1:0] iSeqACG_Command;
  logic [3*Cmds-1:0] iSeqACG_CommandOption;
  logic [Ways*Cmds-1:0] iSeqACG_TargetWay;
  logic [16*Cmds-1:0] iSeqACG_NumOfData;
  logic [Cmds-1:0]   iSeqACG_CASelect;
  logic [40*Cmds-1:0] iSeqACG_CAData;
  logic [16*Cmds-1:0] iSeqACG_WriteData;
  logic [Cmds-1:0]   iSeqACG_WriteLast;
  logic [Cmds-1:0]   iSeqACG_WriteValid;
  logic [8*Cmds-1:0] oSeqACG_LastStep;
  logic [Cmds-1:0]   oSeqACG_WriteReady;
  logic [7:0]        oACG_Command;
  logic [2:0]        oACG_CommandOption;
  logic [Ways-1:0]   oACG_TargetWay;
  logic [15:0]       oACG_NumOfData;
  logic              oACG_CASelect;
  logic [39:0]       oACG_CAData;
  logic [15:0]       oACG_WriteData;
  logic              oACG_WriteLast;
  logic              oACG_WriteValid;
  logic [7:0]        iACG_LastStep;
  logic              iACG_WriteReady;
  logic [Cmds-1:0]   oGrant;
  logic              oLastStep;
  logic              oConflict;
  logic              oUnknownCmd;
  logic              oTimeout;

  int nCompared = 0;
  int nMismatched = 0;

  nfc_command_dispatcher #(
    .NumberOfWays (Ways),
    .NumOfCommands(Cmds),
    .TimeoutWidth (TW)
  ) dut (
    .iSystemClock         (iSystemClock),
    .iReset               (iReset),
    .iCMDValid            (iCMDValid),
    .oCMDReady            (oCMDReady),
    .iSeqStart            (iSeqStart),
    .iSeqLastStep         (iSeqLastStep),
    .iSeqACG_Command      (iSeqACG_Command),
    .iSeqACG_CommandOption(iSeqACG_CommandOption),
    .iSeqACG_TargetWay    (iSeqACG_TargetWay),
    .iSeqACG_NumOfData    (iSeqACG_NumOfData),
    .iSeqACG_CASelect     (iSeqACG_CASelect),
    .iSeqACG_CAData       (iSeqACG_CAData),
    .iSeqACG_WriteData    (iSeqACG_WriteData),
    .iSeqACG_WriteLast    (iSeqACG_WriteLast),
    .iSeqACG_WriteValid   (iSeqACG_WriteValid),
    .oSeqACG_LastStep     (oSeqACG_LastStep),
    .oSeqACG_WriteReady   (oSeqACG_WriteReady),
    .oACG_Command         (oACG_Command),
    .oACG_CommandOption   (oACG_CommandOption),
    .oACG_TargetWay       (oACG_TargetWay),
    .oACG_NumOfData       (oACG_NumOfData),
    .oACG_CASelect        (oACG_CASelect),
    .oACG_CAData          (oACG_CAData),
    .oACG_WriteData       (oACG_WriteData),
    .oACG_WriteLast       (oACG_WriteLast),
    .oACG_WriteValid      (oACG_WriteValid),
    .iACG_LastStep        (iACG_LastStep),
    .iACG_WriteReady      (iACG_WriteReady),
    .oGrant               (oGrant),
    .oLastStep            (oLastStep),
    .oConflict            (oConflict),
    .oUnknownCmd          (oUnknownCmd),
    .oTimeout             (oTimeout)
  );

  initial iSystemClock = 1'b0;
  always #5 iSystemClock = ~iSystemClock;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge iSystemClock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    // Slot constants: Command 8'h10+k, Option k+1, TargetWay 1<<k, NumOfData 16'h0100+k,
    // CASelect 0 (idle value is 1), CAData {8'hee+k, 32'h0}, WriteData 16'ha0a0+k.
    iSeqACG_Command       = {8'h13, 8'h12, 8'h11, 8'h10};
    iSeqACG_CommandOption = {3'd4, 3'd3, 3'd2, 3'd1};
    iSeqACG_TargetWay     = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    iSeqACG_NumOfData     = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    iSeqACG_CASelect      = 4'b0000;
    iSeqACG_CAData        = {40'hf1_00000000, 40'hf0_00000000, 40'hef_00000000, 40'hee_00000000};
    iSeqACG_WriteData     = {16'ha0a3, 16'ha0a2, 16'ha0a1, 16'ha0a0};
    iSeqACG_WriteLast     = 4'b1010;
    iSeqACG_WriteValid    = 4'b0110;
    iReset          = 1'b1;
    iCMDValid       = 1'b0;
    iSeqStart       = '0;
    iSeqLastStep    = '0;
    iACG_LastStep   = 8'h00;
    iACG_WriteReady = 1'b0;

    tick();
    tick();
    check("rst_ready",    64'(oCMDReady),     64'd1);
    check("rst_grant",    64'(oGrant),        64'd0);
    check("rst_laststep", 64'(oLastStep),     64'd0);
    check("rst_conflict", 64'(oConflict),     64'd0);
    check("rst_unknown",  64'(oUnknownCmd),   64'd0);
    check("rst_timeout",  64'(oTimeout),      64'd0);
    check("rst_caselect", 64'(oACG_CASelect), 64'd1);
    check("rst_command",  64'(oACG_Command),  64'd0);

    // Single start on slot 1.
    iReset    = 1'b0;
    iCMDValid = 1'b1;
    iSeqStart = 4'b0010;
    tick();
    iCMDValid = 1'b0;
    iSeqStart = 4'b0000;
    iACG_LastStep   = 8'h5a;
    iACG_WriteReady = 1'b1;
    #1;
    check("g1_grant",     64'(oGrant),             64'h2);
    check("g1_ready",     64'(oCMDReady),          64'd0);
    check("g1_cadata",    64'(oACG_CAData),        64'hef_00000000);
    check("g1_command",   64'(oACG_Command),       64'h11);
    check("g1_option",    64'(oACG_CommandOption), 64'd2);
    check("g1_way",       64'(oACG_TargetWay),     64'h2);
    check("g1_numdata",   64'(oACG_NumOfData),     64'h0101);
    check("g1_caselect",  64'(oACG_CASelect),      64'd0);
    check("g1_wdata",     64'(oACG_WriteData),     64'ha0a1);
    check("g1_wlast",     64'(oACG_WriteLast),     64'd1);
    check("g1_wvalid",    64'(oACG_WriteValid),    64'd1);
    check("g1_conflict",  64'(oConflict),          64'd0);
    check("g1_unknown",   64'(oUnknownCmd),        64'd0);
    check("g1_seqlast",   64'(oSeqACG_LastStep),   64'h00005a00);
    check("g1_seqwready", 64'(oSeqACG_WriteReady), 64'h2);

    // Last step from a non-owner is ignored.
    iSeqLastStep = 4'b0001;
    tick();
    check("g1_nonowner_grant", 64'(oGrant),    64'h2);
    check("g1_nonowner_last",  64'(oLastStep), 64'd0);

    // Owner last step: release then idle.
    iSeqLastStep = 4'b0010;
    tick();
    iSeqLastStep = 4'b0000;
    check("rel_laststep", 64'(oLastStep),          64'd1);
    check("rel_grant",    64'(oGrant),             64'd0);
    check("rel_ready",    64'(oCMDReady),          64'd0);
    check("rel_caselect", 64'(oACG_CASelect),      64'd1);
    check("rel_command",  64'(oACG_Command),       64'd0);
    check("rel_seqwrdy",  64'(oSeqACG_WriteReady), 64'd0);
    tick();
    check("idle_ready",    64'(oCMDReady), 64'd1);
    check("idle_laststep", 64'(oLastStep), 64'd0);

    // Conflict: slots 1 and 2 together, lowest wins.
    iSeqStart = 4'b0110;
    tick();
    iSeqStart = 4'b0000;
    check("cf_grant",    64'(oGrant),             64'h2);
    check("cf_conflict", 64'(oConflict),          64'd1);
    check("cf_seqwrdy",  64'(oSeqACG_WriteReady), 64'h2);
    tick();
    check("cf_pulse_end", 64'(oConflict), 64'd0);
    check("cf_grant_hold", 64'(oGrant),   64'h2);

    // Valid command with no decoder while busy: no pulse; later starts ignored.
    iCMDValid = 1'b1;
    tick();
    check("busy_unknown", 64'(oUnknownCmd), 64'd0);
    iSeqStart = 4'b1000;
    tick();
    check("busy_start_ignored", 64'(oGrant), 64'h2);

    // Owner last step together with a new start: start dropped, no unknown pulse.
    iSeqStart    = 4'b0001;
    iSeqLastStep = 4'b0010;
    tick();
    iSeqStart    = 4'b0000;
    iSeqLastStep = 4'b0000;
    check("sim_grant",   64'(oGrant),      64'd0);
    check("sim_unknown", 64'(oUnknownCmd), 64'd0);
    tick();
    check("sim_rel_unknown", 64'(oUnknownCmd), 64'd0);
    check("sim_rel_grant",   64'(oGrant),      64'd0);
    check("sim_idle_ready",  64'(oCMDReady),   64'd1);
    tick();
    check("unk_pulse", 64'(oUnknownCmd), 64'd1);
    check("unk_grant", 64'(oGrant),      64'd0);
    iCMDValid = 1'b0;
    tick();
    check("unk_pulse_end", 64'(oUnknownCmd), 64'd0);

    // Watchdog: 4-bit counter reaches 15 after 15 busy cycles.
    iSeqStart = 4'b0100;
    tick();
    iSeqStart = 4'b0000;
    check("wd_grant",   64'(oGrant),   64'h4);
    check("wd_initial", 64'(oTimeout), 64'd0);
    repeat (14) tick();
    check("wd_before", 64'(oTimeout), 64'd0);
    tick();
    check("wd_at15", 64'(oTimeout), 64'd1);
    repeat (3) tick();
    check("wd_sticky", 64'(oTimeout), 64'd1);
    check("wd_still_busy", 64'(oGrant), 64'h4);
    iSeqLastStep = 4'b0100;
    tick();
    iSeqLastStep = 4'b0000;
    tick();
    check("wd_idle_hold", 64'(oTimeout), 64'd1);
    iSeqStart = 4'b0001;
    tick();
    iSeqStart = 4'b0000;
    check("wd_clear", 64'(oTimeout), 64'd0);
    check("wd_new_grant", 64'(oGrant), 64'h1);
    check("wd_new_way",   64'(oACG_TargetWay), 64'h1);

    // Reset while busy drops ownership at once.
    iReset = 1'b1;
    tick();
    check("rb_grant",    64'(oGrant),             64'd0);
    check("rb_ready",    64'(oCMDReady),          64'd1);
    check("rb_command",  64'(oACG_Command),       64'd0);
    check("rb_option",   64'(oACG_CommandOption), 64'd0);
    check("rb_way",      64'(oACG_TargetWay),     64'd0);
    check("rb_numdata",  64'(oACG_NumOfData),     64'd0);
    check("rb_caselect", 64'(oACG_CASelect),      64'd1);
    check("rb_cadata",   64'(oACG_CAData),        64'd0);
    check("rb_wdata",    64'(oACG_WriteData),     64'd0);
    check("rb_wlast",    64'(oACG_WriteLast),     64'd0);
    check("rb_wvalid",   64'(oACG_WriteValid),    64'd0);
    check("rb_seqwrdy",  64'(oSeqACG_WriteReady), 64'd0);
    check("rb_seqlast",  64'(oSeqACG_LastStep),   64'd0);
    iReset = 1'b0;
    tick();
    check("rb_after_grant", 64'(oGrant),    64'd0);
    check("rb_after_ready", 64'(oCMDReady), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
